// File: rtl/bcd_convert_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_convert_ctrl
// Description : Sequential binary-to-BCD converter (double-dabble, one input
//               bit per clock). Converts the reaction-time millisecond count
//               into DIGITS BCD digits for the seven-segment display mux.
//               Results above 10^DIGITS-1 saturate to all nines and flag
//               overflow.
// Options     : BCD_BLANK_LEADING_ZERO_EN - when defined, leading zero digits
//               (never digit 0) are replaced by 4'hF, the display blank code.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_convert_ctrl #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int                 C_BCD_W    = 4 * DIGITS;
    localparam int                 C_CAT_W    = C_BCD_W + BIN_W + 1;
    localparam int                 C_CNT_W    = $clog2(BIN_W + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(BIN_W);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [C_BCD_W-1:0] r_scratch;
    logic [BIN_W-1:0]   r_shift;
    logic [C_CNT_W-1:0] r_count;
    logic               r_carry;
    logic [C_BCD_W-1:0] r_bcd;
    logic               r_ovf;
    logic               r_done;

    logic [C_BCD_W-1:0] w_adj;
    logic [C_CAT_W-1:0] w_cat;
    logic [C_BCD_W-1:0] w_final;
`ifdef BCD_BLANK_LEADING_ZERO_EN
    logic               w_lead;
`endif

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: start is only looked at in IDLE, so it never queues.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_SHIFT;
            S_SHIFT: if (r_count == C_CNT_ONE) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Add-3 correction on every digit >= 5, then one-bit left shift of the
    // whole {scratch, shift} register; the top bit of w_cat is the bit lost
    // off the most significant digit.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
        w_cat = {w_adj, r_shift, 1'b0};
    end

    // Result formatting: saturate on carry, optionally blank leading zeros.
    always_comb begin
        w_final = r_carry ? {DIGITS{4'h9}} : r_scratch;
`ifdef BCD_BLANK_LEADING_ZERO_EN
        w_lead = !r_carry;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (w_lead && (r_scratch[4*i +: 4] == 4'h0)) begin
                w_final[4*i +: 4] = 4'hF;
            end else begin
                w_lead = 1'b0;
            end
        end
`endif
    end

    // Datapath: latch on accept, shift in SHIFT, publish result in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scratch <= '0;
            r_shift   <= '0;
            r_count   <= '0;
            r_carry   <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift   <= bin_in;
                        r_scratch <= '0;
                        r_carry   <= 1'b0;
                        r_count   <= C_CNT_INIT;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_cat[C_CAT_W-2:BIN_W];
                    r_shift   <= w_cat[BIN_W-1:0];
                    r_carry   <= r_carry | w_cat[C_CAT_W-1];
                    r_count   <= r_count - C_CNT_ONE;
                end
                S_DONE: begin
                    r_bcd  <= w_final;
                    r_ovf  <= r_carry;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state == S_SHIFT);
    assign done     = r_done;
    assign bcd_out  = r_bcd;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bcd_convert_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_convert_ctrl
// Description : Directed self-checking bench for bcd_convert_ctrl. Expected
//               results are pushed to a scoreboard queue when a conversion is
//               started and popped when done pulses.
// Options     : honours BCD_BLANK_LEADING_ZERO_EN in its reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_convert_ctrl;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [BIN_W-1:0]  bin_in;
    logic              busy;
    logic              done;
    logic [15:0]       bcd_out;
    logic              overflow;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    bcd_convert_ctrl #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model built from decimal arithmetic.
    function automatic exp_t model(input int v);
        exp_t        e;
        logic [3:0]  d;
        logic        lead;
        if (v > 9999) begin
            e.bcd = 16'h9999;
            e.ovf = 1'b1;
        end else begin
            e.ovf = 1'b0;
            e.bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
`ifdef BCD_BLANK_LEADING_ZERO_EN
            lead = 1'b1;
            for (int i = 3; i >= 1; i--) begin
                d = e.bcd[4*i +: 4];
                if (lead && d == 4'h0) e.bcd[4*i +: 4] = 4'hF;
                else lead = 1'b0;
            end
`endif
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard and compare against the current outputs.
    task automatic sb_compare(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() > 0)
        else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_bcd"}, 32'(bcd_out), 32'(e.bcd));
            chk({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
        end
    endtask

    // One conversion; optionally re-pulse start (bin_in=500) in SHIFT cycle
    // disturb_at to show it is ignored.
    task automatic run_conv(input int value, input int disturb_at, input string tag);
        int lat;
        int busy_cnt;
        start  = 1'b1;
        bin_in = BIN_W'(value);
        sb.push_back(model(value));
        tick();
        start    = 1'b0;
        bin_in   = BIN_W'($urandom_range(0, 16383));
        busy_cnt = busy ? 1 : 0;
        lat      = 0;
        while (!done && lat < 40) begin
            if (lat + 1 == disturb_at) begin
                start  = 1'b1;
                bin_in = BIN_W'(500);
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(BIN_W + 1));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(BIN_W));
        sb_compare(tag);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic no_done_for(input int n, input string tag);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) cnt++;
        end
        chk(tag, 32'(cnt), 32'd0);
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        run_conv(255, 0, "c255");
        run_conv(9999, 0, "c9999");
        run_conv(0, 0, "c0");
        run_conv(12000, 0, "c12000");
        run_conv(42, 0, "c42");
        run_conv(16383, 0, "cmax");
        run_conv(7, 5, "c7_ignore");
        no_done_for(20, "ignore_no_extra_done");

        // Asynchronous abort mid-conversion.
        start  = 1'b1;
        bin_in = BIN_W'(1234);
        sb.push_back(model(1234));
        tick();
        start = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bcd", 32'(bcd_out), 32'd0);
        chk("abort_ovf", 32'(overflow), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        no_done_for(20, "abort_no_done");
        run_conv(1234, 0, "c1234");

        // start held high: back-to-back conversions every BIN_W+2 cycles.
        start = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            bin_in = BIN_W'(v);
            sb.push_back(model(v));
            n = 0;
            do begin
                tick();
                n++;
                if (n == 2) bin_in = BIN_W'($urandom_range(100, 16383));
            end while (!done && n < 60);
            if (v == 3) start = 1'b0;
            chk($sformatf("b2b%0d_period", v), 32'(n), 32'(BIN_W + 2));
            sb_compare($sformatf("b2b%0d", v));
        end
        start = 1'b0;
        no_done_for(20, "b2b_stop");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
